pcie_symbol_lock_ctrl: RTL and testbench

Receive-side symbol-lock controller that sequences the serial-to-parallel comma aligner of one PCIe lane. It watches deserialized 10-bit symbols and decoder error flags, declares symbol lock after a run of clean commas, and tracks symbol errors with a leaky error level. On loss of lock or a watchdog expiry it drives a multi-cycle realign pulse into the aligner's reset. It sits between the per-lane SIPO/aligner and the 8b/10b decoder status, and feeds `symbol_lock` to the LTSSM.

---
 rtl/pcie_symbol_lock_ctrl_if.sv | 27 ++
 rtl/pcie_symbol_lock_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pcie_symbol_lock_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_symbol_lock_ctrl_if.sv
// Symbol stream from one lane's SIPO/aligner into the symbol-lock controller.
// The controller drives realign back into the aligner's reset.
interface pcie_symbol_lock_ctrl_if #(
  parameter int DATA_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] sym_in;
  logic                  sym_valid;
  logic                  sym_err;
  logic                  aligner_lock;
  logic                  realign;

  modport master (
    output sym_in,
    output sym_valid,
    output sym_err,
    output aligner_lock,
    input  realign
  );

  modport slave (
    input  sym_in,
    input  sym_valid,
    input  sym_err,
    input  aligner_lock,
    output realign
  );
endinterface

// File: rtl/pcie_symbol_lock_ctrl.sv
// Per-lane PCIe receive symbol-lock controller: comma acquisition, leaky error level, watchdog, realign pulse.
// Optional PCIE_SYMLOCK_STATS_EN adds a saturating lock_loss_count output.
module pcie_symbol_lock_ctrl #(
  parameter int DATA_WIDTH     = 10,
  parameter int ACQ_COMMAS     = 3,
  parameter int ERR_LIMIT      = 4,
  parameter int GOOD_RUN       = 4,
  parameter int TIMEOUT        = 1024,
  parameter int REALIGN_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  pcie_symbol_lock_ctrl_if.slave         sym_if,
  input  logic [DATA_WIDTH-1:0]          comma_char,
  output logic                           symbol_lock,
  output logic [1:0]                     state_out,
  output logic [$clog2(ERR_LIMIT+1)-1:0] err_level
`ifdef PCIE_SYMLOCK_STATS_EN
  ,
  output logic [15:0]                    lock_loss_count
`endif
);

  localparam int RCW = $clog2(REALIGN_CYCLES + 1);
  localparam int CCW = $clog2(ACQ_COMMAS + 1);
  localparam int ELW = $clog2(ERR_LIMIT + 1);
  localparam int GRW = $clog2(GOOD_RUN + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [RCW-1:0] RC_LAST  = RCW'(REALIGN_CYCLES - 1);
  localparam logic [CCW-1:0] ACQ_LAST = CCW'(ACQ_COMMAS - 1);
  localparam logic [ELW-1:0] ERR_LAST = ELW'(ERR_LIMIT - 1);
  localparam logic [GRW-1:0] RUN_LAST = GRW'(GOOD_RUN - 1);
  localparam logic [WDW-1:0] WD_EXP   = WDW'(TIMEOUT - 2);
  localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_REALIGN = 2'd0,
    ST_HUNT    = 2'd1,
    ST_ACQUIRE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [RCW-1:0] realign_cnt, realign_cnt_nxt;
  logic [CCW-1:0] comma_cnt, comma_cnt_nxt;
  logic [ELW-1:0] err_q, err_nxt;
  logic [GRW-1:0] run_cnt, run_nxt;
  logic [WDW-1:0] wd_cnt, wd_nxt, wd_inc;
  logic           clean_comma;
  logic           go_realign;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_REALIGN;
      realign_cnt <= '0;
      comma_cnt   <= '0;
      err_q       <= '0;
      run_cnt     <= '0;
      wd_cnt      <= '0;
    end else begin
      state       <= state_nxt;
      realign_cnt <= realign_cnt_nxt;
      comma_cnt   <= comma_cnt_nxt;
      err_q       <= err_nxt;
      run_cnt     <= run_nxt;
      wd_cnt      <= wd_nxt;
    end
  end

  // Branch order inside each state encodes priority: aligner drop, watchdog, error limit, symbol.
  always_comb begin
    state_nxt       = state;
    realign_cnt_nxt = realign_cnt;
    comma_cnt_nxt   = comma_cnt;
    err_nxt         = err_q;
    run_nxt         = run_cnt;
    wd_nxt          = wd_cnt;
    go_realign      = 1'b0;
    clean_comma     = sym_if.sym_valid && !sym_if.sym_err &&
                      ((sym_if.sym_in == comma_char) || (sym_if.sym_in == ~comma_char));
    wd_inc          = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 1'b1;

    case (state)
      ST_REALIGN: begin
        if (realign_cnt == RC_LAST) begin
          state_nxt = ST_HUNT;
        end else begin
          realign_cnt_nxt = realign_cnt + 1'b1;
        end
      end
      ST_HUNT: begin
        if (clean_comma) begin
          wd_nxt = '0;
          if (sym_if.aligner_lock) begin
            if (ACQ_COMMAS == 1) begin
              state_nxt = ST_LOCKED;
              run_nxt   = '0;
            end else begin
              state_nxt     = ST_ACQUIRE;
              comma_cnt_nxt = CCW'(1);
            end
          end
        end else if (wd_cnt == WD_EXP) begin
          go_realign = 1'b1;
        end else begin
          wd_nxt = wd_inc;
        end
      end
      ST_ACQUIRE: begin
        if (!sym_if.aligner_lock) begin
          go_realign = 1'b1;
        end else if (clean_comma) begin
          wd_nxt = '0;
          if (comma_cnt == ACQ_LAST) begin
            state_nxt     = ST_LOCKED;
            comma_cnt_nxt = '0;
            run_nxt       = '0;
          end else begin
            comma_cnt_nxt = comma_cnt + 1'b1;
          end
        end else if (wd_cnt == WD_EXP) begin
          go_realign = 1'b1;
        end else if (sym_if.sym_valid && sym_if.sym_err) begin
          state_nxt     = ST_HUNT;
          comma_cnt_nxt = '0;
          wd_nxt        = '0;
        end else begin
          wd_nxt = wd_inc;
        end
      end
      ST_LOCKED: begin
        if (!sym_if.aligner_lock) begin
          go_realign = 1'b1;
        end else if (!sym_if.sym_valid) begin
          if (wd_cnt == WD_EXP) begin
            go_realign = 1'b1;
          end else begin
            wd_nxt = wd_inc;
          end
        end else begin
          wd_nxt = '0;
          if (sym_if.sym_err) begin
            if (err_q == ERR_LAST) begin
              go_realign = 1'b1;
            end else begin
              err_nxt = err_q + 1'b1;
              run_nxt = '0;
            end
          end else if (run_cnt == RUN_LAST) begin
            err_nxt = (err_q == '0) ? err_q : err_q - 1'b1;
            run_nxt = '0;
          end else begin
            run_nxt = run_cnt + 1'b1;
          end
        end
      end
      default: go_realign = 1'b1;
    endcase

    if (go_realign) begin
      state_nxt       = ST_REALIGN;
      realign_cnt_nxt = '0;
      comma_cnt_nxt   = '0;
      err_nxt         = '0;
      run_nxt         = '0;
      wd_nxt          = '0;
    end
  end

`ifdef PCIE_SYMLOCK_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_count <= '0;
    end else if (state == ST_LOCKED && state_nxt == ST_REALIGN &&
                 lock_loss_count != 16'hFFFF) begin
      lock_loss_count <= lock_loss_count + 16'd1;
    end
  end
`endif

  assign sym_if.realign = (state == ST_REALIGN);
  assign symbol_lock    = (state == ST_LOCKED);
  assign state_out      = state;
  assign err_level      = err_q;

endmodule

// File: tb/tb_pcie_symbol_lock_ctrl.sv
// Self-checking bench for pcie_symbol_lock_ctrl: directed scenarios plus random traffic against a rule-level model.
// Honours PCIE_SYMLOCK_STATS_EN so lock_loss_count is checked when the feature is built in.
module tb_pcie_symbol_lock_ctrl;

  localparam int ACQ_COMMAS     = 3;
  localparam int ERR_LIMIT      = 4;
  localparam int GOOD_RUN       = 4;
  localparam int TIMEOUT        = 1024;
  localparam int REALIGN_CYCLES = 4;
  localparam logic [9:0] COMMA  = 10'h17C;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] comma_char = COMMA;
  logic       symbol_lock;
  logic [1:0] state_out;
  logic [2:0] err_level;
`ifdef PCIE_SYMLOCK_STATS_EN
  logic [15:0] lock_loss_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int m_state;
  int m_realign_left;
  int m_commas;
  int m_level;
  int m_run;
  int m_idle;
  int m_losses;

  pcie_symbol_lock_ctrl_if #(.DATA_WIDTH(10)) bus ();

  pcie_symbol_lock_ctrl #(
    .DATA_WIDTH(10), .ACQ_COMMAS(ACQ_COMMAS), .ERR_LIMIT(ERR_LIMIT),
    .GOOD_RUN(GOOD_RUN), .TIMEOUT(TIMEOUT), .REALIGN_CYCLES(REALIGN_CYCLES)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sym_if(bus.slave),
    .comma_char(comma_char),
    .symbol_lock(symbol_lock),
    .state_out(state_out),
    .err_level(err_level)
`ifdef PCIE_SYMLOCK_STATS_EN
    ,
    .lock_loss_count(lock_loss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Model states: 0 realign, 1 hunt, 2 acquire, 3 locked; counts are plain "events so far".
  task automatic model_enter_realign(input bit from_locked);
    if (from_locked) m_losses = (m_losses == 65535) ? m_losses : m_losses + 1;
    m_state = 0; m_realign_left = REALIGN_CYCLES;
    m_commas = 0; m_level = 0; m_run = 0; m_idle = 0;
  endtask

  task automatic model_reset();
    m_losses = 0;
    model_enter_realign(1'b0);
  endtask

  task automatic model_edge(input logic v, input logic e, input logic [9:0] s, input logic al);
    bit comma;
    comma = v && !e && (s == COMMA || s == ~COMMA);
    case (m_state)
      0: begin
        m_realign_left--;
        if (m_realign_left == 0) m_state = 1;
      end
      1: begin
        if (comma) begin
          m_idle = 0;
          if (al) begin
            m_commas = 1;
            m_state = (m_commas >= ACQ_COMMAS) ? 3 : 2;
          end
        end else begin
          m_idle++;
          if (m_idle >= TIMEOUT - 1) model_enter_realign(1'b0);
        end
      end
      2: begin
        if (!al) model_enter_realign(1'b0);
        else if (comma) begin
          m_idle = 0;
          m_commas++;
          if (m_commas >= ACQ_COMMAS) begin
            m_state = 3; m_commas = 0; m_run = 0;
          end
        end else begin
          m_idle++;
          if (m_idle >= TIMEOUT - 1) model_enter_realign(1'b0);
          else if (v && e) begin
            m_state = 1; m_commas = 0; m_idle = 0;
          end
        end
      end
      default: begin
        if (!al) model_enter_realign(1'b1);
        else if (!v) begin
          m_idle++;
          if (m_idle >= TIMEOUT - 1) model_enter_realign(1'b1);
        end else begin
          m_idle = 0;
          if (e) begin
            if (m_level + 1 >= ERR_LIMIT) model_enter_realign(1'b1);
            else begin
              m_level++; m_run = 0;
            end
          end else begin
            m_run++;
            if (m_run == GOOD_RUN) begin
              m_level = (m_level > 0) ? m_level - 1 : 0;
              m_run = 0;
            end
          end
        end
      end
    endcase
  endtask

  task automatic compare_all(input string tag);
    check_output({tag, ":state"}, 32'(state_out), m_state);
    check_output({tag, ":realign"}, 32'(bus.realign), (m_state == 0) ? 1 : 0);
    check_output({tag, ":lock"}, 32'(symbol_lock), (m_state == 3) ? 1 : 0);
    check_output({tag, ":err_level"}, 32'(err_level), m_level);
`ifdef PCIE_SYMLOCK_STATS_EN
    check_output({tag, ":loss_count"}, 32'(lock_loss_count), m_losses);
`endif
  endtask

  task automatic apply_stimulus(input logic v, input logic e, input logic [9:0] s, input logic al);
    bus.sym_valid = v;
    bus.sym_err = e;
    bus.sym_in = s;
    bus.aligner_lock = al;
    model_edge(v, e, s, al);
    @(posedge clk);
    #1;
    compare_all("step");
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("reset_async");
    @(posedge clk);
    #1;
    compare_all("reset_hold");
    reset_n = 1'b1;
  endtask

  function automatic logic [9:0] rand_data();
    logic [9:0] s;
    s = 10'($urandom_range(0, 1023));
    while (s == COMMA || s == ~COMMA) s = s + 10'd1;
    return s;
  endfunction

  function automatic logic [9:0] rand_comma();
    logic [9:0] s;
    s = ($urandom_range(0, 1) != 0) ? COMMA : ~COMMA;
    return s;
  endfunction

  initial begin
    logic v, e, al;
    logic [9:0] s;
    bus.sym_valid = 1'b0;
    bus.sym_err = 1'b0;
    bus.sym_in = '0;
    bus.aligner_lock = 1'b0;
    model_reset();
    #2;
    do_reset();

    $display("[TB] reset exit");
    for (int k = 1; k <= REALIGN_CYCLES; k++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_comma(), 1'b1);
      if (k < REALIGN_CYCLES) check_output("realign_hold", 32'(bus.realign), 1);
    end
    check_output("hunt_entry", 32'(state_out), 1);
    check_output("hunt_err_level", 32'(err_level), 0);

    $display("[TB] acquire");
    apply_stimulus(1'b1, 1'b0, 10'h17C, 1'b1);
    apply_stimulus(1'b1, 1'b0, rand_data(), 1'b1);
    apply_stimulus(1'b1, 1'b0, 10'h283, 1'b1);
    apply_stimulus(1'b0, 1'b0, rand_data(), 1'b1);
    check_output("acq_not_yet", 32'(symbol_lock), 0);
    apply_stimulus(1'b1, 1'b0, 10'h17C, 1'b1);
    check_output("acq_locked", 32'(symbol_lock), 1);

    $display("[TB] leaky errors");
    apply_stimulus(1'b1, 1'b1, rand_data(), 1'b1);
    check_output("leaky_l1", 32'(err_level), 1);
    for (int k = 0; k < GOOD_RUN; k++) apply_stimulus(1'b1, 1'b0, rand_data(), 1'b1);
    check_output("leaky_l0", 32'(err_level), 0);
    apply_stimulus(1'b1, 1'b1, rand_data(), 1'b1);
    apply_stimulus(1'b1, 1'b1, rand_data(), 1'b1);
    check_output("leaky_l2", 32'(err_level), 2);
    apply_stimulus(1'b1, 1'b1, rand_data(), 1'b1);
    check_output("leaky_l3", 32'(err_level), 3);
    apply_stimulus(1'b1, 1'b1, rand_data(), 1'b1);
    check_output("leaky_realign", 32'(bus.realign), 1);
    check_output("leaky_unlock", 32'(symbol_lock), 0);
`ifdef PCIE_SYMLOCK_STATS_EN
    check_output("leaky_loss", 32'(lock_loss_count), 1);
`endif
    for (int k = 0; k < REALIGN_CYCLES; k++) apply_stimulus(1'b1, 1'b0, rand_comma(), 1'b1);

    $display("[TB] acquire abort");
    apply_stimulus(1'b1, 1'b0, COMMA, 1'b1);
    apply_stimulus(1'b1, 1'b0, ~COMMA, 1'b1);
    apply_stimulus(1'b1, 1'b1, rand_data(), 1'b1);
    check_output("abort_hunt", 32'(state_out), 1);
    apply_stimulus(1'b1, 1'b0, COMMA, 1'b1);
    apply_stimulus(1'b1, 1'b0, COMMA, 1'b1);
    check_output("abort_still_acq", 32'(state_out), 2);
    apply_stimulus(1'b1, 1'b0, COMMA, 1'b1);
    check_output("abort_relock", 32'(state_out), 3);

    $display("[TB] watchdog");
    for (int k = 0; k < TIMEOUT - 2; k++) apply_stimulus(1'b0, 1'b0, rand_data(), 1'b1);
    check_output("wd_near", 32'(state_out), 3);
    apply_stimulus(1'b1, 1'b0, rand_data(), 1'b1);
    check_output("wd_saved", 32'(state_out), 3);
    for (int k = 0; k < TIMEOUT - 2; k++) apply_stimulus(1'b0, 1'b1, rand_data(), 1'b1);
    check_output("wd_before_expiry", 32'(symbol_lock), 1);
    apply_stimulus(1'b0, 1'b0, rand_data(), 1'b1);
    check_output("wd_expired", 32'(bus.realign), 1);
    for (int k = 0; k < REALIGN_CYCLES; k++) apply_stimulus(1'b0, 1'b0, rand_data(), 1'b0);

    $display("[TB] priority");
    for (int k = 0; k < ACQ_COMMAS; k++) apply_stimulus(1'b1, 1'b0, rand_comma(), 1'b1);
    for (int k = 0; k < ERR_LIMIT - 1; k++) apply_stimulus(1'b1, 1'b1, rand_data(), 1'b1);
    check_output("prio_level", 32'(err_level), 3);
    apply_stimulus(1'b1, 1'b1, rand_data(), 1'b0);
    check_output("prio_realign", 32'(bus.realign), 1);
    check_output("prio_err_cleared", 32'(err_level), 0);
`ifdef PCIE_SYMLOCK_STATS_EN
    check_output("prio_loss", 32'(lock_loss_count), 3);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      v = ($urandom_range(0, 3) != 0);
      e = ($urandom_range(0, 15) == 0);
      al = ($urandom_range(0, 40) != 0);
      s = ($urandom_range(0, 2) == 0) ? rand_comma() : rand_data();
      apply_stimulus(v, e, s, al);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
